// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide execute unit: pipelined multiplier, iterative
// restoring divider, valid/ready handshakes on both sides and a flush kill.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int DIV_BITS   = 1,
    parameter int MUL_STAGES = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [7:0]      MUL_LAST = 8'(MUL_STAGES - 1);
    localparam logic [7:0]      DIV_LAST = 8'(XLEN / DIV_BITS - 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t          state_q, state_n;
    logic            accept;
    logic [4:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, result_q;
    logic [7:0]      cnt_q;
    logic [XLEN-1:0] dv_quo_q, dv_rem_q, dv_den_q, dv_quo_n, dv_rem_n;
    logic [XLEN:0]   dv_shift;
    logic            neg_q_q, neg_r_q;

    // Request decode happens on the live inputs so the fast path resolves at accept.
    logic            is_mul_in, is_div_in, signed_in, rem_in, div_zero_in, ovf_in, fast_in;
    logic [XLEN-1:0] fast_result, rs1_mag, rs2_mag;

    assign accept      = in_valid_i && in_ready_o;
    assign is_mul_in   = (op_i >= OP_MUL) && (op_i <= OP_MULHU);
    assign is_div_in   = (op_i >= OP_DIV) && (op_i <= OP_REMU);
    assign signed_in   = (op_i == OP_DIV) || (op_i == OP_REM);
    assign rem_in      = (op_i == OP_REM) || (op_i == OP_REMU);
    assign div_zero_in = (rs2_i == '0);
    assign ovf_in      = signed_in && (rs1_i == SMIN) && (rs2_i == '1);
    assign fast_in     = !is_mul_in && (!is_div_in || div_zero_in || ovf_in);
    assign rs1_mag     = (signed_in && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign rs2_mag     = (signed_in && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

    always_comb begin
        fast_result = '0;
        if (is_div_in) begin
            if (div_zero_in)
                fast_result = rem_in ? rs1_i : '1;
            else if (ovf_in)
                fast_result = rem_in ? '0 : rs1_i;
        end
    end

    // Sign-extending to 2*XLEN gives the same low 2*XLEN bits as an (XLEN+1)-bit signed product.
    logic            mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    logic [XLEN-1:0] mul_sel, mul_out;

    assign mul_sa   = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
    assign mul_sb   = (op_q == OP_MULH) && b_q[XLEN-1];
    assign mul_a    = {{XLEN{mul_sa}}, a_q};
    assign mul_b    = {{XLEN{mul_sb}}, b_q};
    assign mul_prod = mul_a * mul_b;
    assign mul_sel  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    generate
        if (MUL_STAGES == 1) begin : g_mul_direct
            assign mul_out = mul_sel;
        end else begin : g_mul_pipe
            logic [XLEN-1:0] pipe [MUL_STAGES-1];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= mul_sel;
                    for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign mul_out = pipe[MUL_STAGES-2];
        end
    endgenerate

    always_comb begin
        dv_rem_n = dv_rem_q;
        dv_quo_n = dv_quo_q;
        dv_shift = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            dv_shift = {dv_rem_n, dv_quo_n[XLEN-1]};
            dv_quo_n = {dv_quo_n[XLEN-2:0], 1'b0};
            if (dv_shift >= {1'b0, dv_den_q}) begin
                dv_rem_n    = dv_shift[XLEN-1:0] - dv_den_q;
                dv_quo_n[0] = 1'b1;
            end else begin
                dv_rem_n = dv_shift[XLEN-1:0];
            end
        end
    end

    logic [XLEN-1:0] quo_fix, rem_fix, fix_result;
    assign quo_fix    = neg_q_q ? -dv_quo_q : dv_quo_q;
    assign rem_fix    = neg_r_q ? -dv_rem_q : dv_rem_q;
    assign fix_result = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: if (accept) state_n = is_mul_in ? MUL : (fast_in ? DONE : DIV);
            MUL:  if (cnt_q == MUL_LAST) state_n = DONE;
            DIV:  if (cnt_q == DIV_LAST) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: if (out_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill_i) state_n = IDLE;
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE) && rst_ni && !kill_i;
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            dv_quo_q <= '0;
            dv_rem_q <= '0;
            dv_den_q <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= op_i;
            a_q      <= rs1_i;
            b_q      <= rs2_i;
            cnt_q    <= '0;
            dv_quo_q <= rs1_mag;
            dv_rem_q <= '0;
            dv_den_q <= rs2_mag;
            neg_q_q  <= signed_in && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_r_q  <= signed_in && rs1_i[XLEN-1];
            if (fast_in) result_q <= fast_result;
        end else if (!kill_i) begin
            unique case (state_q)
                MUL: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == MUL_LAST) result_q <= mul_out;
                end
                DIV: begin
                    cnt_q    <= cnt_q + 8'd1;
                    dv_quo_q <= dv_quo_n;
                    dv_rem_q <= dv_rem_n;
                end
                FIX:     result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

endmodule
